pwm_multichannel: RTL and testbench

Multi-channel PWM generator sharing one period counter across `NumChannels` compare outputs, with edge- or center-aligned modes, per-channel polarity, and double-buffered (shadow) configuration that only takes effect on period boundaries. It is the generalised successor to the single-channel `pwm` block and sits in the system peripheral area, driven by a register interface (LEDs, motor/servo drive, backlight).

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_channel_cmp.sv | 58 +++++
 rtl/pwm_multichannel.sv | 132 +++++++++++++
 tb/tb_pwm_multichannel.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block.
//   pwm_dir_e   : counter direction (center-aligned mode counts back down)
//   pwm_mode_e  : edge- or center-aligned period shape
//   pwm_cfg_t   : period/mode configuration word, held staged and active
package pwm_pkg;

  typedef enum logic {DirUp, DirDown} pwm_dir_e;
  typedef enum logic {ModeEdge, ModeCenter} pwm_mode_e;

  // Widest supported counter; the period field is zero-extended to this width.
  localparam int unsigned PwmPeriodW = 32;

  typedef struct packed {
    logic [PwmPeriodW-1:0] period;
    pwm_mode_e             mode;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM compare channel: staged and active width/invert, compare against the
// shared counter, and the registered output.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : capture width_i/invert_i into the staged copy
//   apply_i        : copy staged into active
//   idle_i         : counter idle; output parks at the inversion level
//   width_i        : staged pulse width
//   invert_i       : staged output inversion
//   cnt_i          : shared period counter
//   modulated_o    : registered PWM output
module pwm_channel_cmp #(
  parameter int unsigned CtrSize = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               apply_i,
  input  logic               idle_i,
  input  logic [CtrSize-1:0] width_i,
  input  logic               invert_i,
  input  logic [CtrSize-1:0] cnt_i,
  output logic               modulated_o
);

  logic [CtrSize-1:0] width_stage_q, width_stage_d;
  logic [CtrSize-1:0] width_q, width_d;
  logic               invert_stage_q, invert_stage_d;
  logic               invert_q, invert_d;
  logic               mod_q, mod_d;

  always_comb begin
    width_stage_d  = load_i  ? width_i        : width_stage_q;
    invert_stage_d = load_i  ? invert_i       : invert_stage_q;
    width_d        = apply_i ? width_stage_q  : width_q;
    invert_d       = apply_i ? invert_stage_q : invert_q;
    // Output is always derived from the values active in this cycle.
    mod_d          = idle_i ? invert_q : ((width_q > cnt_i) ^ invert_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_stage_q  <= '0;
      invert_stage_q <= 1'b0;
      width_q        <= '0;
      invert_q       <= 1'b0;
      mod_q          <= 1'b0;
    end else begin
      width_stage_q  <= width_stage_d;
      invert_stage_q <= invert_stage_d;
      width_q        <= width_d;
      invert_q       <= invert_d;
      mod_q          <= mod_d;
    end
  end

  assign modulated_o = mod_q;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: one shared period counter (edge- or
// center-aligned) feeding NumChannels compare channels. Configuration is
// double-buffered and only becomes active on a period boundary or while idle.
//   clk_sys_i, rst_sys_i : clock, synchronous active-high reset
//   en_i                 : run enable
//   load_i               : strobe, capture all config inputs into staged copy
//   center_i             : staged mode (0 edge, 1 center)
//   max_counter_i        : staged period value
//   pulse_width_i        : staged widths, channel i at [i*CtrSize +: CtrSize]
//   invert_i             : staged per-channel inversion
//   load_pending_o       : staged config not yet applied
//   period_end_o         : pulse in the first cycle of each new period
//   modulated_o          : registered PWM outputs
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned CtrSize     = 8  // must not exceed PwmPeriodW
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_sys_i,
  input  logic                           en_i,
  input  logic                           load_i,
  input  logic                           center_i,
  input  logic [CtrSize-1:0]             max_counter_i,
  input  logic [NumChannels*CtrSize-1:0] pulse_width_i,
  input  logic [NumChannels-1:0]         invert_i,
  output logic                           load_pending_o,
  output logic                           period_end_o,
  output logic [NumChannels-1:0]         modulated_o
);

  pwm_cfg_t           cfg_in;
  pwm_cfg_t           cfg_stage_q, cfg_stage_d;
  pwm_cfg_t           cfg_q, cfg_d;
  logic               pending_q, pending_d;
  logic               period_end_q, period_end_d;
  logic [CtrSize-1:0] cnt_q, cnt_d;
  pwm_dir_e           dir_q, dir_d;

  logic                  idle;
  logic                  at_top;
  logic                  boundary;
  logic                  apply;
  logic [PwmPeriodW-1:0] cnt_ext;

  assign cfg_in.period = PwmPeriodW'(max_counter_i);
  assign cfg_in.mode   = center_i ? ModeCenter : ModeEdge;
  assign cnt_ext       = PwmPeriodW'(cnt_q);

  assign idle   = !en_i || (cfg_q.period == '0);
  assign at_top = (cnt_ext == cfg_q.period);

  // Center mode ends on the way down at 1; with P==1 there is no down leg,
  // so the cycle at the top is also the last one.
  always_comb begin
    boundary = 1'b0;
    if (!idle) begin
      if (cfg_q.mode == ModeEdge) begin
        boundary = at_top;
      end else begin
        boundary = (cnt_q == CtrSize'(1)) && ((dir_q == DirDown) || at_top);
      end
    end
  end

  assign apply = pending_q && (idle || boundary);

  always_comb begin
    cfg_stage_d  = load_i ? cfg_in : cfg_stage_q;
    cfg_d        = apply ? cfg_stage_q : cfg_q;
    // A load coinciding with an apply keeps the flag set for the new data.
    pending_d    = load_i ? 1'b1 : (apply ? 1'b0 : pending_q);
    period_end_d = boundary;

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (idle || boundary) begin
      cnt_d = '0;
      dir_d = DirUp;
    end else if (cfg_q.mode == ModeEdge) begin
      cnt_d = cnt_q + CtrSize'(1);
    end else if (dir_q == DirUp) begin
      if (at_top) begin
        cnt_d = cnt_q - CtrSize'(1);
        dir_d = DirDown;
      end else begin
        cnt_d = cnt_q + CtrSize'(1);
      end
    end else begin
      cnt_d = cnt_q - CtrSize'(1);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cfg_stage_q  <= '0;
      cfg_q        <= '0;
      pending_q    <= 1'b0;
      period_end_q <= 1'b0;
      cnt_q        <= '0;
      dir_q        <= DirUp;
    end else begin
      cfg_stage_q  <= cfg_stage_d;
      cfg_q        <= cfg_d;
      pending_q    <= pending_d;
      period_end_q <= period_end_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
    end
  end

  assign load_pending_o = pending_q;
  assign period_end_o   = period_end_q;

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    pwm_channel_cmp #(
      .CtrSize(CtrSize)
    ) u_cmp (
      .clk_i      (clk_sys_i),
      .rst_i      (rst_sys_i),
      .load_i     (load_i),
      .apply_i    (apply),
      .idle_i     (idle),
      .width_i    (pulse_width_i[i*CtrSize +: CtrSize]),
      .invert_i   (invert_i[i]),
      .cnt_i      (cnt_q),
      .modulated_o(modulated_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel (4 channels, 8-bit counter).
module tb_pwm_multichannel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        center = 1'b0;
  logic [7:0]  max_counter = '0;
  logic [31:0] pulse_width = '0;
  logic [3:0]  invert = '0;
  logic        load_pending;
  logic        period_end;
  logic [3:0]  modulated;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multichannel #(
    .NumChannels(4),
    .CtrSize    (8)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_i     (rst),
    .en_i          (en),
    .load_i        (load),
    .center_i      (center),
    .max_counter_i (max_counter),
    .pulse_width_i (pulse_width),
    .invert_i      (invert),
    .load_pending_o(load_pending),
    .period_end_o  (period_end),
    .modulated_o   (modulated)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             center;
    logic [7:0]       p;
    logic [3:0][7:0]  w;
    logic [3:0]       inv;
    int               len;
    logic [3:0][9:0]  high;  // high cycles per period, per channel
  } vec_t;

  vec_t vecs [6];
  vec_t v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    center = 1'b0; max_counter = '0; pulse_width = '0; invert = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_pe(input int limit, output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int c = 0; c < limit; c++) begin
      if (period_end) begin
        ok = 1'b1;
        break;
      end
      tick();
      lat++;
    end
  endtask

  bit ok;
  int lat;
  int pe_cnt;
  int hi [4];
  int cnt;

  initial begin
    // center, P, widths {w3,w2,w1,w0}, inv, period length, highs {h3,h2,h1,h0}
    vecs[0] = '{1'b0, 8'd9,   {8'd10, 8'd9, 8'd0, 8'd3},  4'b0000, 10,
                {10'd10, 10'd9, 10'd0, 10'd3}};
    vecs[1] = '{1'b1, 8'd4,   {8'd4, 8'd0, 8'd5, 8'd2},   4'b0000, 8,
                {10'd7, 10'd0, 10'd8, 10'd3}};
    vecs[2] = '{1'b0, 8'd255, {8'd255, 8'd254, 8'd1, 8'd0}, 4'b0000, 256,
                {10'd255, 10'd254, 10'd1, 10'd0}};
    vecs[3] = '{1'b0, 8'd9,   {8'd3, 8'd3, 8'd0, 8'd3},   4'b1010, 10,
                {10'd7, 10'd3, 10'd10, 10'd3}};
    vecs[4] = '{1'b1, 8'd1,   {8'd1, 8'd2, 8'd0, 8'd1},   4'b0000, 2,
                {10'd1, 10'd2, 10'd0, 10'd1}};
    vecs[5] = '{1'b1, 8'd3,   {8'd9, 8'd3, 8'd2, 8'd1},   4'b0001, 6,
                {10'd6, 10'd5, 10'd3, 10'd5}};

    // Reset state, and nothing runs with period 0.
    tick();
    do_reset();
    chk("rst_pending", int'(load_pending), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_mod", int'(modulated), 0);
    en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(modulated != 4'b0) + int'(period_end);
    end
    chk("rst_no_run", cnt, 0);

    // Table: steady-state period length and duty per configuration.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      do_reset();
      center = v.center; max_counter = v.p; pulse_width = v.w; invert = v.inv;
      en = 1'b1; load = 1'b1;
      tick();
      load = 1'b0;
      wait_pe(1000, ok, lat);
      chk($sformatf("v%0d_sync", i), int'(ok), 1);
      chk($sformatf("v%0d_first_pe", i), lat, v.len + 1);
      pe_cnt = 0;
      for (int c = 0; c < 4; c++) hi[c] = 0;
      for (int k = 0; k < 2 * v.len; k++) begin
        pe_cnt += int'(period_end);
        for (int c = 0; c < 4; c++) hi[c] += int'(modulated[c]);
        tick();
      end
      chk($sformatf("v%0d_pe_count", i), pe_cnt, 2);
      for (int c = 0; c < 4; c++)
        chk($sformatf("v%0d_ch%0d_high", i, c), hi[c], 2 * int'(v.high[c]));
    end

    // Idle level follows inversion; inverted W=0 channel stays high when running.
    do_reset();
    max_counter = 8'd9; pulse_width = '0; invert = 4'b0010; load = 1'b1;
    tick();
    load = 1'b0;
    chk("idle_pending_set", int'(load_pending), 1);
    tick();
    chk("idle_pending_clr", int'(load_pending), 0);
    tick();
    chk("idle_mod", int'(modulated), 2);
    en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(modulated == 4'b0010);
    end
    chk("inv_run_mod", cnt, 20);

    // Period 0 while enabled: outputs equal invert bits, no period pulses.
    do_reset();
    max_counter = 8'd0; pulse_width = {4{8'd5}}; invert = 4'b1011;
    en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("p0_mod", int'(modulated), 11);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt += int'(period_end) + int'(modulated != 4'b1011);
    end
    chk("p0_steady", cnt, 0);

    // Reload mid-period, then reload on the boundary cycle.
    do_reset();
    max_counter = 8'd9; pulse_width = {24'd0, 8'd3}; en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    wait_pe(100, ok, lat);
    chk("rl_sync", int'(ok), 1);
    hi[0] = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      hi[0] += int'(modulated[0]);
      if (k == 4) begin
        pulse_width = {24'd0, 8'd7};
        load = 1'b1;
      end
      if (k == 5) begin
        load = 1'b0;
        chk("rl_pending_mid", int'(load_pending), 1);
      end
    end
    chk("rl_pe1", int'(period_end), 1);
    chk("rl_pending_clr", int'(load_pending), 0);
    chk("rl_old_duty", hi[0], 3);
    hi[0] = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      hi[0] += int'(modulated[0]);
      if (k == 9) begin
        pulse_width = {24'd0, 8'd2};
        load = 1'b1;
      end
    end
    load = 1'b0;
    chk("rl_new_duty", hi[0], 7);
    chk("rl_pe2", int'(period_end), 1);
    chk("rl_bnd_pending", int'(load_pending), 1);
    hi[0] = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      hi[0] += int'(modulated[0]);
    end
    chk("rl_held_duty", hi[0], 7);
    chk("rl_bnd_applied", int'(load_pending), 0);
    hi[0] = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      hi[0] += int'(modulated[0]);
    end
    chk("rl_late_duty", hi[0], 2);
    en = 1'b0;
    tick();
    chk("en_fall_mod", int'(modulated), 0);
    chk("en_fall_pe", int'(period_end), 0);

    // Reset mid-period with a load pending discards everything.
    do_reset();
    max_counter = 8'd9; pulse_width = {4{8'd3}}; en = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    wait_pe(100, ok, lat);
    chk("mr_sync", int'(ok), 1);
    for (int k = 0; k < 4; k++) tick();
    pulse_width = {4{8'd7}}; load = 1'b1;
    tick();
    load = 1'b0;
    chk("mr_pending", int'(load_pending), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_pending_clr", int'(load_pending), 0);
    chk("mr_mod", int'(modulated), 0);
    chk("mr_pe", int'(period_end), 0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt += int'(modulated != 4'b0) + int'(period_end) + int'(load_pending);
    end
    chk("mr_idle", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
